// File: rtl/ballot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ballot_sequencer_if
// Brief    : Booth-side signal bundle between voter controls and the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ballot_sequencer_if #(
    parameter int NUM_CAND = 4,
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 16
);
    logic                valid_vote;
    logic [NUM_CAND-1:0] cand_btn;
    logic                mode;
    logic                vote_pulse;
    logic [IDX_W-1:0]    vote_idx;
    logic                green_led;
    logic                red_led;
    logic                timeout_pulse;
    logic [CNT_W-1:0]    total_votes;

    modport master (
        output valid_vote, cand_btn, mode,
        input  vote_pulse, vote_idx, green_led, red_led, timeout_pulse, total_votes
    );

    modport slave (
        input  valid_vote, cand_btn, mode,
        output vote_pulse, vote_idx, green_led, red_led, timeout_pulse, total_votes
    );
endinterface
`default_nettype wire

// File: rtl/ballot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ballot_sequencer
// Brief    : Per-booth voting-cycle controller: arm, debounce, cast, lock out.
// Revision : 1.0 - initial release
// ============================================================================
module ballot_sequencer #(
    parameter int NUM_CAND    = 4,
    parameter int IDX_W       = 2,
    parameter int DEBOUNCE    = 50000,
    parameter int TIMEOUT     = 100000000,
    parameter int LOCK_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    ballot_sequencer_if.slave bus
);
    localparam int c_TMR_W = $clog2(TIMEOUT);
    localparam int c_DB_W  = $clog2(DEBOUNCE);
    localparam int c_LK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [NUM_CAND-1:0] c_ONE = NUM_CAND'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_DEBOUNCE = 3'd2,
        S_CAST     = 3'd3,
        S_HOLD     = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_TMR_W-1:0]  r_tmr;
    logic [c_DB_W-1:0]   r_db;
    logic [c_LK_W-1:0]   r_lock;
    logic [NUM_CAND-1:0] r_pend_oh;
    logic [IDX_W-1:0]    r_pend_idx;
    logic [IDX_W-1:0]    r_vote_idx;
    logic [CNT_W-1:0]    r_total;
    logic                r_timeout_pulse;

    logic                w_onehot;
    logic                w_tmo;
    logic [IDX_W-1:0]    w_btn_idx;

    assign w_onehot = (bus.cand_btn != '0) &&
                      ((bus.cand_btn & (bus.cand_btn - c_ONE)) == '0);
    assign w_tmo    = (r_tmr == c_TMR_W'(TIMEOUT - 1));

    // Only meaningful when the buttons are one-hot.
    always_comb begin
        w_btn_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.cand_btn[i]) w_btn_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_tmr           <= '0;
            r_db            <= '0;
            r_lock          <= '0;
            r_pend_oh       <= '0;
            r_pend_idx      <= '0;
            r_vote_idx      <= '0;
            r_total         <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_vote && !bus.mode) begin
                        r_state <= S_ARMED;
                        r_tmr   <= '0;
                    end
                end
                S_ARMED, S_DEBOUNCE: begin
                    r_tmr <= r_tmr + 1'b1;
                    // Admin mode aborts silently; timeout beats a same-edge cast.
                    if (bus.mode) begin
                        r_state <= S_IDLE;
                    end else if (w_tmo) begin
                        r_state         <= S_IDLE;
                        r_timeout_pulse <= 1'b1;
                    end else if (r_state == S_ARMED) begin
                        if (w_onehot) begin
                            r_pend_oh  <= bus.cand_btn;
                            r_pend_idx <= w_btn_idx;
                            r_db       <= '0;
                            r_state    <= S_DEBOUNCE;
                        end
                    end else if (bus.cand_btn != r_pend_oh) begin
                        r_state <= S_ARMED;
                    end else if (r_db == c_DB_W'(DEBOUNCE - 1)) begin
                        r_state    <= S_CAST;
                        r_vote_idx <= r_pend_idx;
                        if (r_total != '1) r_total <= r_total + 1'b1;
                    end else begin
                        r_db <= r_db + 1'b1;
                    end
                end
                S_CAST: begin
                    r_state <= S_HOLD;
                    r_lock  <= '0;
                end
                S_HOLD: begin
                    if (r_lock == c_LK_W'(LOCK_CYCLES - 1)) r_state <= S_RELEASE;
                    else                                    r_lock  <= r_lock + 1'b1;
                end
                S_RELEASE: begin
                    if (bus.cand_btn == '0) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.vote_pulse    = (r_state == S_CAST);
    assign bus.green_led     = (r_state == S_ARMED) || (r_state == S_DEBOUNCE);
    assign bus.red_led       = (r_state != S_IDLE);
    assign bus.timeout_pulse = r_timeout_pulse;
    assign bus.vote_idx      = r_vote_idx;
    assign bus.total_votes   = r_total;
endmodule
`default_nettype wire
